// File: rtl/rsp_ahb_lite_decoder_param.sv
// Parametrised single-master AHB-Lite address decoder and response multiplexer.
// The address and control path passes straight through. A registered data-phase
// select steers the slave responses back to the master. The block also contains
// a two-cycle ERROR default slave, one remappable region and a stalled-slave
// timeout monitor.
module rsp_ahb_lite_decoder_param #(
    parameter int unsigned                    NUM_SLAVES  = 3,
    parameter int unsigned                    ADDR_W      = 32,
    parameter int unsigned                    DATA_W      = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_BASE    = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_MASK    = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
    parameter logic [ADDR_W-1:0]              REMAP_BASE  = '0,
    parameter int unsigned                    REMAP_SLV   = 0,
    parameter int unsigned                    TIMEOUT_CYC = 256
) (
    input  logic                           HCLK,
    input  logic                           HRESET,
    input  logic [3:0]                     REMAP,
    input  logic [ADDR_W-1:0]              HADDRS,
    input  logic [1:0]                     HTRANSS,
    input  logic                           HWRITES,
    input  logic [2:0]                     HSIZES,
    input  logic [2:0]                     HBURSTS,
    input  logic [3:0]                     HPROTS,
    input  logic [DATA_W-1:0]              HWDATAS,
    input  logic                           HMASTLOCKS,
    output logic [DATA_W-1:0]              HRDATAS,
    output logic                           HREADYS,
    output logic                           HRESPS,
    output logic [NUM_SLAVES-1:0]          HSELM,
    output logic [ADDR_W-1:0]              HADDRM,
    output logic [1:0]                     HTRANSM,
    output logic                           HWRITEM,
    output logic [2:0]                     HSIZEM,
    output logic [2:0]                     HBURSTM,
    output logic [3:0]                     HPROTM,
    output logic [DATA_W-1:0]              HWDATAM,
    output logic                           HMASTLOCKM,
    output logic                           HREADYMUX,
    input  logic [NUM_SLAVES*DATA_W-1:0]   HRDATAM,
    input  logic [NUM_SLAVES-1:0]          HREADYOUTM,
    input  logic [NUM_SLAVES-1:0]          HRESPM,
    input  logic                           TIMEOUT_CLR,
    output logic                           TIMEOUT_IRQ,
    output logic [2:0]                     TIMEOUT_SLV
);

    localparam int unsigned       IDX_W      = 3;
    localparam int unsigned       CNT_W      = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  TO_MAX     = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic              TO_EN      = (TIMEOUT_CYC != 0);
    localparam logic [ADDR_W-1:0] REMAP_MASK = SLV_MASK[REMAP_SLV*ADDR_W +: ADDR_W];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } err_state_t;

    logic                 dec_hit;
    logic [IDX_W-1:0]     dec_idx;
    logic                 dsel_slv_q;
    logic [IDX_W-1:0]     dsel_idx_q;
    err_state_t           err_state_q;
    logic                 err_act_q;
    logic                 err_rdy_q;
    logic [CNT_W-1:0]     to_cnt_q;
    logic                 to_irq_q;
    logic [IDX_W-1:0]     to_slv_q;
    logic                 hready;
    logic                 hresp;
    logic [DATA_W-1:0]    hrdata;
    logic                 accept_err;
    logic                 stall;
    logic                 to_hit;
    logic                 unused_remap;

    // Broadcast the master address/control/write-data bus to every slave.
    assign HADDRM     = HADDRS;
    assign HTRANSM    = HTRANSS;
    assign HWRITEM    = HWRITES;
    assign HSIZEM     = HSIZES;
    assign HBURSTM    = HBURSTS;
    assign HPROTM     = HPROTS;
    assign HWDATAM    = HWDATAS;
    assign HMASTLOCKM = HMASTLOCKS;

    assign unused_remap = ^REMAP[3:1];

    // Address decode: lowest matching index wins, the remap region overrides all.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        HSELM   = '0;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if ((HADDRS & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
        if (REMAP[0] && ((HADDRS & REMAP_MASK) == (REMAP_BASE & REMAP_MASK))) begin
            dec_hit = 1'b1;
            dec_idx = IDX_W'(REMAP_SLV);
        end
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (dec_hit && (dec_idx == IDX_W'(i))) begin
                HSELM[i] = 1'b1;
            end
        end
    end

    // Response mux: default slave first, then the selected real slave, else OKAY.
    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        if (err_act_q) begin
            hready = err_rdy_q;
            hresp  = 1'b1;
        end else if (dsel_slv_q) begin
            for (int i = 0; i < int'(NUM_SLAVES); i++) begin
                if (dsel_idx_q == IDX_W'(i)) begin
                    hready = HREADYOUTM[i];
                    hresp  = HRESPM[i];
                    hrdata = HRDATAM[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign HREADYS     = hready;
    assign HREADYMUX   = hready;
    assign HRESPS      = hresp;
    assign HRDATAS     = hrdata;
    assign TIMEOUT_IRQ = to_irq_q;
    assign TIMEOUT_SLV = to_slv_q;

    assign accept_err = hready && HTRANSS[1] && !dec_hit;
    assign stall      = dsel_slv_q && !hready;
    assign to_hit     = TO_EN && stall && (to_cnt_q == TO_LAST);

    // Data-phase select: captured whenever an address phase is accepted.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel_slv_q <= 1'b0;
            dsel_idx_q <= '0;
        end else if (hready) begin
            dsel_slv_q <= HTRANSS[1] && dec_hit;
            dsel_idx_q <= dec_idx;
        end
    end

    // Default slave: two-cycle ERROR response for unmapped NONSEQ/SEQ transfers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_state_q <= ST_IDLE;
            err_act_q   <= 1'b0;
            err_rdy_q   <= 1'b1;
        end else begin
            case (err_state_q)
                ST_IDLE: begin
                    if (accept_err) begin
                        err_state_q <= ST_ERR1;
                        err_act_q   <= 1'b1;
                        err_rdy_q   <= 1'b0;
                    end
                end
                ST_ERR1: begin
                    err_state_q <= ST_ERR2;
                    err_rdy_q   <= 1'b1;
                end
                ST_ERR2: begin
                    if (accept_err) begin
                        err_state_q <= ST_ERR1;
                        err_rdy_q   <= 1'b0;
                    end else begin
                        err_state_q <= ST_IDLE;
                        err_act_q   <= 1'b0;
                    end
                end
                default: begin
                    err_state_q <= ST_IDLE;
                    err_act_q   <= 1'b0;
                    err_rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    // Timeout monitor: saturating wait-state counter with sticky status; set beats clear.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            to_cnt_q <= '0;
            to_irq_q <= 1'b0;
            to_slv_q <= '0;
        end else begin
            if (!stall) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != TO_MAX) begin
                to_cnt_q <= to_cnt_q + CNT_W'(1);
            end
            if (to_hit) begin
                to_irq_q <= 1'b1;
                if (!to_irq_q) begin
                    to_slv_q <= dsel_idx_q;
                end
            end else if (TIMEOUT_CLR) begin
                to_irq_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rsp_ahb_lite_decoder_param.sv
// Directed bench for rsp_ahb_lite_decoder_param with a response scoreboard.
module tb_rsp_ahb_lite_decoder_param;

    localparam int unsigned NS = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic [3:0]        REMAP;
    logic [AW-1:0]     HADDRS;
    logic [1:0]        HTRANSS;
    logic              HWRITES;
    logic [2:0]        HSIZES;
    logic [2:0]        HBURSTS;
    logic [3:0]        HPROTS;
    logic [DW-1:0]     HWDATAS;
    logic              HMASTLOCKS;
    logic [DW-1:0]     HRDATAS;
    logic              HREADYS;
    logic              HRESPS;
    logic [NS-1:0]     HSELM;
    logic [AW-1:0]     HADDRM;
    logic [1:0]        HTRANSM;
    logic              HWRITEM;
    logic [2:0]        HSIZEM;
    logic [2:0]        HBURSTM;
    logic [3:0]        HPROTM;
    logic [DW-1:0]     HWDATAM;
    logic              HMASTLOCKM;
    logic              HREADYMUX;
    logic [NS*DW-1:0]  HRDATAM;
    logic [NS-1:0]     HREADYOUTM;
    logic [NS-1:0]     HRESPM;
    logic              TIMEOUT_CLR;
    logic              TIMEOUT_IRQ;
    logic [2:0]        TIMEOUT_SLV;

    logic [DW-1:0]     s_rdata [NS];
    logic [NS-1:0]     s_ready;
    logic [NS-1:0]     s_resp;

    logic [DW:0]       exp_q [$];
    int                n_tests = 0;
    int                n_fail  = 0;
    bit                pend    = 1'b0;

    always #5 HCLK = ~HCLK;

    assign HRDATAM    = {s_rdata[2], s_rdata[1], s_rdata[0]};
    assign HREADYOUTM = s_ready;
    assign HRESPM     = s_resp;

    rsp_ahb_lite_decoder_param #(
        .NUM_SLAVES  (NS),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .SLV_BASE    ({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK    ({32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
        .REMAP_BASE  (32'h0000_0000),
        .REMAP_SLV   (1),
        .TIMEOUT_CYC (16)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .REMAP       (REMAP),
        .HADDRS      (HADDRS),
        .HTRANSS     (HTRANSS),
        .HWRITES     (HWRITES),
        .HSIZES      (HSIZES),
        .HBURSTS     (HBURSTS),
        .HPROTS      (HPROTS),
        .HWDATAS     (HWDATAS),
        .HMASTLOCKS  (HMASTLOCKS),
        .HRDATAS     (HRDATAS),
        .HREADYS     (HREADYS),
        .HRESPS      (HRESPS),
        .HSELM       (HSELM),
        .HADDRM      (HADDRM),
        .HTRANSM     (HTRANSM),
        .HWRITEM     (HWRITEM),
        .HSIZEM      (HSIZEM),
        .HBURSTM     (HBURSTM),
        .HPROTM      (HPROTM),
        .HWDATAM     (HWDATAM),
        .HMASTLOCKM  (HMASTLOCKM),
        .HREADYMUX   (HREADYMUX),
        .HRDATAM     (HRDATAM),
        .HREADYOUTM  (HREADYOUTM),
        .HRESPM      (HRESPM),
        .TIMEOUT_CLR (TIMEOUT_CLR),
        .TIMEOUT_IRQ (TIMEOUT_IRQ),
        .TIMEOUT_SLV (TIMEOUT_SLV)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr(input logic [AW-1:0] a, input logic [1:0] t, input logic w);
        HADDRS  = a;
        HTRANSS = t;
        HWRITES = w;
    endtask

    task automatic expect_rsp(input logic r, input logic [DW-1:0] d);
        exp_q.push_back({r, d});
    endtask

    // Monitor: a data phase completes on a negedge with HREADYS high; compare it against the queue.
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                pend = 1'b0;
            end else if (HREADYS) begin
                if (pend) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got data 0x%0h resp %0d, expected no response", HRDATAS, HRESPS);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_data", 64'(HRDATAS), 64'(e[DW-1:0]));
                        check("rsp_resp", 64'(HRESPS), 64'(e[DW]));
                    end
                end
                pend = HTRANSS[1];
            end
        end
    end

    // Hard bound on total simulation time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        HRESET      = 1'b1;
        REMAP       = 4'h0;
        HADDRS      = '0;
        HTRANSS     = T_IDLE;
        HWRITES     = 1'b0;
        HSIZES      = 3'b010;
        HBURSTS     = 3'b000;
        HPROTS      = 4'b0011;
        HWDATAS     = '0;
        HMASTLOCKS  = 1'b0;
        TIMEOUT_CLR = 1'b0;
        s_ready     = '1;
        s_resp      = '0;
        for (int i = 0; i < int'(NS); i++) s_rdata[i] = '0;

        repeat (2) tick();
        check("rst_hready", 64'(HREADYS), 64'd1);
        check("rst_hresp", 64'(HRESPS), 64'd0);
        check("rst_hrdata", 64'(HRDATAS), 64'd0);
        check("rst_irq", 64'(TIMEOUT_IRQ), 64'd0);
        check("rst_slv", 64'(TIMEOUT_SLV), 64'd0);
        HRESET = 1'b0;

        // 1: NONSEQ read to slave0, zero waits
        s_rdata[0] = 32'hA5A5_A5A5;
        addr(32'h0000_0010, T_NONSEQ, 1'b0);
        #1;
        check("t1_hsel", 64'(HSELM), 64'b001);
        check("t1_haddrm", 64'(HADDRM), 64'h10);
        check("t1_htransm", 64'(HTRANSM), 64'(T_NONSEQ));
        expect_rsp(1'b0, 32'hA5A5_A5A5);
        tick();
        addr(32'h0000_0010, T_IDLE, 1'b0);
        #1;
        check("t1_hreadymux", 64'(HREADYMUX), 64'd1);

        // 2: remap sends the low region to slave1; plain decode patterns
        tick();
        REMAP      = 4'h1;
        s_rdata[1] = 32'h5A5A_1111;
        addr(32'h0000_0010, T_NONSEQ, 1'b0);
        #1;
        check("t2_hsel_remap", 64'(HSELM), 64'b010);
        expect_rsp(1'b0, 32'h5A5A_1111);
        tick();
        REMAP = 4'h0;
        addr(32'h0000_0010, T_IDLE, 1'b0);
        #1;
        check("t2_hsel_noremap", 64'(HSELM), 64'b001);
        addr(32'h1000_0004, T_IDLE, 1'b0);
        #1;
        check("t2_hsel_s1", 64'(HSELM), 64'b010);
        addr(32'h2FFF_FFFC, T_IDLE, 1'b0);
        #1;
        check("t2_hsel_s2", 64'(HSELM), 64'b100);
        addr(32'hF000_0000, T_IDLE, 1'b0);
        #1;
        check("t2_hsel_none", 64'(HSELM), 64'b000);

        // 3: unmapped NONSEQ gets a two-cycle ERROR, then IDLE gets OKAY
        tick();
        addr(32'hF000_0000, T_NONSEQ, 1'b0);
        #1;
        check("t3_hsel", 64'(HSELM), 64'b000);
        expect_rsp(1'b1, 32'h0);
        tick();
        addr(32'hF000_0000, T_IDLE, 1'b0);
        #1;
        check("t3_err1_ready", 64'(HREADYS), 64'd0);
        check("t3_err1_resp", 64'(HRESPS), 64'd1);
        tick();
        check("t3_err2_ready", 64'(HREADYS), 64'd1);
        check("t3_err2_resp", 64'(HRESPS), 64'd1);
        tick();
        check("t3_idle_ready", 64'(HREADYS), 64'd1);
        check("t3_idle_resp", 64'(HRESPS), 64'd0);
        // back-to-back unmapped: ERR2 loops straight into ERR1
        addr(32'hF000_0004, T_NONSEQ, 1'b0);
        expect_rsp(1'b1, 32'h0);
        tick();
        addr(32'hF000_0008, T_NONSEQ, 1'b0);
        expect_rsp(1'b1, 32'h0);
        tick();
        check("t3_b2b_err2_ready", 64'(HREADYS), 64'd1);
        tick();
        addr(32'hF000_0008, T_IDLE, 1'b0);
        #1;
        check("t3_b2b_err1_ready", 64'(HREADYS), 64'd0);
        check("t3_b2b_err1_resp", 64'(HRESPS), 64'd1);
        tick();
        check("t3_b2b_err2_resp", 64'(HRESPS), 64'd1);
        tick();
        check("t3_b2b_idle_resp", 64'(HRESPS), 64'd0);

        // 4: write slave2 (2 waits) then slave0; slave0 must not be muxed early
        s_rdata[2] = 32'h2222_2222;
        s_rdata[0] = 32'h0000_AAAA;
        addr(32'h2000_0000, T_NONSEQ, 1'b1);
        expect_rsp(1'b0, 32'h2222_2222);
        tick();
        HWDATAS    = 32'hDEAD_0002;
        s_ready[2] = 1'b0;
        addr(32'h0000_0020, T_NONSEQ, 1'b1);
        expect_rsp(1'b0, 32'h0000_AAAA);
        #1;
        check("t4_wait1_ready", 64'(HREADYS), 64'd0);
        check("t4_wait1_hwdatam", 64'(HWDATAM), 64'hDEAD_0002);
        check("t4_wait1_rdata", 64'(HRDATAS), 64'h2222_2222);
        tick();
        check("t4_wait2_ready", 64'(HREADYS), 64'd0);
        check("t4_wait2_hwdatam", 64'(HWDATAM), 64'hDEAD_0002);
        tick();
        s_ready[2] = 1'b1;
        #1;
        check("t4_s2_done_ready", 64'(HREADYS), 64'd1);
        tick();
        HWDATAS = 32'hDEAD_0000;
        addr(32'h0000_0020, T_IDLE, 1'b0);
        #1;
        check("t4_s0_hwdatam", 64'(HWDATAM), 64'hDEAD_0000);
        check("t4_s0_rdata", 64'(HRDATAS), 64'h0000_AAAA);

        // 5: slave1 stalls 20 cycles; irq after the 16th wait, then clear
        tick();
        s_rdata[1] = 32'h1111_0005;
        addr(32'h1000_0000, T_NONSEQ, 1'b0);
        expect_rsp(1'b0, 32'h1111_0005);
        tick();
        addr(32'h1000_0000, T_IDLE, 1'b0);
        s_ready[1] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 16) begin
                #1;
                check("t5_irq_before", 64'(TIMEOUT_IRQ), 64'd0);
            end
            if (k == 17) begin
                #1;
                check("t5_irq_set", 64'(TIMEOUT_IRQ), 64'd1);
                check("t5_slv", 64'(TIMEOUT_SLV), 64'd1);
                check("t5_not_aborted", 64'(HREADYS), 64'd0);
            end
            tick();
        end
        s_ready[1] = 1'b1;
        #1;
        check("t5_irq_sticky", 64'(TIMEOUT_IRQ), 64'd1);
        tick();
        TIMEOUT_CLR = 1'b1;
        tick();
        TIMEOUT_CLR = 1'b0;
        #1;
        check("t5_irq_cleared", 64'(TIMEOUT_IRQ), 64'd0);
        // set and clear in the same cycle: set wins
        s_rdata[2] = 32'h2222_0006;
        addr(32'h2000_0004, T_NONSEQ, 1'b0);
        expect_rsp(1'b0, 32'h2222_0006);
        tick();
        addr(32'h2000_0004, T_IDLE, 1'b0);
        s_ready[2] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) TIMEOUT_CLR = 1'b1;
            tick();
        end
        TIMEOUT_CLR = 1'b0;
        s_ready[2]  = 1'b1;
        #1;
        check("t5_set_wins_irq", 64'(TIMEOUT_IRQ), 64'd1);
        check("t5_set_wins_slv", 64'(TIMEOUT_SLV), 64'd2);
        tick();
        TIMEOUT_CLR = 1'b1;
        tick();
        TIMEOUT_CLR = 1'b0;
        #1;
        check("t5_irq_cleared2", 64'(TIMEOUT_IRQ), 64'd0);

        // 6: reset during a slave0 wait drops the data phase and the irq
        s_rdata[0] = 32'h0BAD_0000;
        addr(32'h0000_0040, T_NONSEQ, 1'b0);
        tick();
        addr(32'h0000_0040, T_IDLE, 1'b0);
        s_ready[0] = 1'b0;
        repeat (17) tick();
        check("t6_pre_irq", 64'(TIMEOUT_IRQ), 64'd1);
        check("t6_pre_ready", 64'(HREADYS), 64'd0);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        #1;
        check("t6_ready", 64'(HREADYS), 64'd1);
        check("t6_resp", 64'(HRESPS), 64'd0);
        check("t6_rdata", 64'(HRDATAS), 64'd0);
        check("t6_irq", 64'(TIMEOUT_IRQ), 64'd0);
        s_ready[0] = 1'b1;
        s_rdata[0] = 32'h0000_7777;
        addr(32'h0000_0040, T_NONSEQ, 1'b0);
        expect_rsp(1'b0, 32'h0000_7777);
        tick();
        addr(32'h0000_0040, T_IDLE, 1'b0);
        repeat (2) tick();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
